mem_bus_interface: RTL and testbench

- Sits directly upstream of the multicycle decoder/control unit.
- Turns the CPU's single-request memory accesses (instruction fetch, LW/LB/SW and later LH/SB/SH) into Avalon-style bus transactions with waitrequest.
- Produces the `stall` the decoder holds EXEC_1 on, and returns aligned, extended load data.
- Owns the instruction register that drives the decoder's `Instr` input.

---
 rtl/mips_mem_pkg.sv | 51 +++++
 rtl/mem_load_align.sv | 33 +++
 rtl/mem_bus_interface.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_interface.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and lane helpers for the CPU memory bus interface.
// Sizes and bus states are enums so the size decode reads as names.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } bus_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic access_ok(input size_t size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: access_ok = 1'b1;
            SIZE_HALF: access_ok = ~off[0];
            SIZE_WORD: access_ok = (off == 2'b00);
            default:   access_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input size_t size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_enable = BE_BYTE0 << off;
            SIZE_HALF: lane_enable = off[1] ? BE_HALF_HI : BE_HALF_LO;
            SIZE_WORD: lane_enable = BE_WORD;
            default:   lane_enable = BE_NONE;
        endcase
    endfunction

    // Stores are replicated so the addressed lanes carry the data whatever the offset.
    function automatic logic [31:0] lane_replicate(input size_t size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: lane_replicate = {4{data[7:0]}};
            SIZE_HALF: lane_replicate = {2{data[15:0]}};
            default:   lane_replicate = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it; word loads pass straight through.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] readdata_i,
    input  logic [1:0]  addr_i,
    input  size_t       size_i,
    input  logic        signed_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = readdata_i[7:0];
        case (addr_i)
            2'd0:    lane_byte = readdata_i[7:0];
            2'd1:    lane_byte = readdata_i[15:8];
            2'd2:    lane_byte = readdata_i[23:16];
            default: lane_byte = readdata_i[31:24];
        endcase
        lane_half = addr_i[1] ? readdata_i[31:16] : readdata_i[15:0];

        case (size_i)
            SIZE_BYTE: rdata_o = {{24{signed_i & lane_byte[7]}}, lane_byte};
            SIZE_HALF: rdata_o = {{16{signed_i & lane_half[15]}}, lane_half};
            default:   rdata_o = readdata_i;
        endcase
    end

endmodule

// File: rtl/mem_bus_interface.sv
// CPU single-request to Avalon-style bus bridge with waitrequest, stall
// generation, load alignment and the decoder's instruction register.
//
// state  | meaning
// IDLE   | no access in flight; a request is latched and checked here
// ACCESS | bus strobe held until waitrequest drops or the timeout expires
// DONE   | one cycle with stall released; rdata/mem_error valid
module mem_bus_interface
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic        ir_write,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] instr,
    output logic        mem_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    bus_state_t       state_q, state_d;
    logic [31:0]      address_q, address_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    size_t            size_q, size_d;
    logic             signed_q, signed_d;
    logic             ir_q, ir_d;
    logic             dual_q, dual_d;

    size_t            req_size;
    logic [31:0]      load_data;

    mem_load_align u_load_align (
        .readdata_i (readdata),
        .addr_i     (off_q),
        .size_i     (size_q),
        .signed_i   (signed_q),
        .rdata_o    (load_data)
    );

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        size_d    = size_q;
        signed_d  = signed_q;
        ir_d      = ir_q;
        dual_d    = dual_q;
        req_size  = size_t'(cpu_size);

        case (state_q)
            IDLE: begin
                if (cpu_read | cpu_write) begin
                    address_d = {cpu_addr[31:2], 2'b00};
                    wdata_d   = lane_replicate(req_size, cpu_wdata);
                    off_d     = cpu_addr[1:0];
                    size_d    = req_size;
                    signed_d  = cpu_signed;
                    ir_d      = ir_write;
                    dual_d    = cpu_read & cpu_write;
                    cnt_d     = '0;
                    if (access_ok(req_size, cpu_addr[1:0])) begin
                        be_d    = lane_enable(req_size, cpu_addr[1:0]);
                        read_d  = cpu_read;
                        write_d = ~cpu_read;
                        state_d = ACCESS;
                    end else begin
                        be_d    = BE_NONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (waitrequest) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_d == TO_VAL)) begin
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    if (read_q) begin
                        rdata_d = load_data;
                        if (ir_q) begin
                            instr_d = load_data;
                        end
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = dual_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= '0;
            be_q      <= BE_NONE;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            instr_q   <= RESET_INSTR;
            cnt_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= SIZE_BYTE;
            signed_q  <= 1'b0;
            ir_q      <= 1'b0;
            dual_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            ir_q      <= ir_d;
            dual_q    <= dual_d;
        end
    end

    assign stall      = (cpu_read | cpu_write) && (state_q != DONE);
    assign rdata      = rdata_q;
    assign instr      = instr_q;
    assign mem_error  = err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Self-checking bench for mem_bus_interface: directed cases then random
// requests, all compared against a transaction-level reference model.
module tb_mem_bus_interface;

    localparam int unsigned TO        = 4;
    localparam logic [31:0] RST_INSTR = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_signed, ir_write;
    logic        stall;
    logic [31:0] rdata, instr;
    logic        mem_error;
    logic [31:0] address;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_instr;

    mem_bus_interface #(
        .TIMEOUT_CYCLES (TO),
        .RESET_INSTR    (RST_INSTR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_size    (cpu_size),
        .cpu_signed  (cpu_signed),
        .ir_write    (ir_write),
        .stall       (stall),
        .rdata       (rdata),
        .instr       (instr),
        .mem_error   (mem_error),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        case (size)
            2'b00: begin
                v = (w >> (8 * off)) & 32'h0000_00FF;
                if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (16 * off[1])) & 32'h0000_FFFF;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] b;
        case (size)
            2'b00:   begin b = 4'b0001; b = b << off; end
            2'b01:   begin b = 4'b0011; b = b << off; end
            default: b = 4'b1111;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {24'h0, d[7:0]} * 32'h0101_0101;
            2'b01:   return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Called just after a rising edge with the DUT idle; returns the same way.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic sgn, input logic irw, input int waits,
                           input logic [31:0] rdword);
        logic        bad, tmo, err;
        int          done_cyc;
        logic [31:0] ld;
        bad = (size == 2'b11) || (size == 2'b10 && addr[1:0] != 2'b00) ||
              (size == 2'b01 && addr[0]);
        tmo = !bad && (waits >= int'(TO));
        err = bad || tmo || (rd && wr);
        done_cyc = bad ? 1 : (tmo ? 1 + int'(TO) : 2 + waits);
        ld = ref_load(rdword, addr[1:0], size, sgn);

        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        cpu_size = size; cpu_signed = sgn; ir_write = irw; readdata = rdword;
        for (int c = 0; c <= done_cyc; c++) begin
            waitrequest = (c >= 1 && c <= waits);
            @(negedge clk);
            chk("stall", 32'(stall), 32'(c < done_cyc));
            chk("read", 32'(read), 32'(!bad && rd && c >= 1 && c < done_cyc));
            chk("write", 32'(write), 32'(!bad && wr && !rd && c >= 1 && c < done_cyc));
            chk("mem_error", 32'(mem_error), 32'(c == done_cyc && err));
            if (c == 1 && !bad) begin
                chk("address", address, {addr[31:2], 2'b00});
                chk("byteenable", 32'(byteenable), 32'(ref_be(size, addr[1:0])));
                if (wr && !rd) chk("writedata", writedata, ref_wd(size, wdata));
            end
            if (c == done_cyc) begin
                if (bad || tmo) chk("rdata_err", rdata, 32'h0);
                else if (rd)    chk("rdata", rdata, ld);
                if (rd && irw && !bad && !tmo) exp_instr = ld;
            end
            chk("instr", instr, exp_instr);
            @(posedge clk); #1;
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        waitrequest = 1'($urandom_range(0, 1));
        readdata = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_strobe", 32'({read, write}), 32'h0);
        chk("idle_error", 32'(mem_error), 32'h0);
        chk("idle_instr", instr, exp_instr);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_size = 2'b10; cpu_signed = 1'b0; ir_write = 1'b0;
        readdata = '0; waitrequest = 1'b0;
        exp_instr = RST_INSTR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_strobe", 32'({read, write, mem_error}), 32'h0);
        chk("rst_be", 32'(byteenable), 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_instr", instr, RST_INSTR);
        reset = 1'b0;
        @(posedge clk); #1;

        // fetch, LB signed with waits, SB, misaligned LW, timeout
        run_txn(1, 0, 32'hBFC0_0000, 32'h0,          2'b10, 0, 1, 0,  32'h2402_0005);
        run_txn(1, 0, 32'h0000_1003, 32'h0,          2'b00, 1, 0, 3,  32'h80FF_1234);
        run_txn(0, 1, 32'h0000_2001, 32'h0000_00AB,  2'b00, 0, 0, 0,  32'h0);
        run_txn(1, 0, 32'h0000_1002, 32'h0,          2'b10, 0, 0, 0,  32'hCAFE_F00D);
        run_txn(1, 0, 32'h0000_4000, 32'h0,          2'b10, 0, 1, 20, 32'h1111_1111);
        run_txn(1, 0, 32'h0000_5002, 32'h0,          2'b01, 0, 0, 1,  32'h8001_7FFF);
        run_txn(1, 0, 32'h0000_5002, 32'h0,          2'b01, 1, 0, 0,  32'h8001_7FFF);
        run_txn(1, 0, 32'h0000_5001, 32'h0,          2'b01, 1, 0, 0,  32'h8001_7FFF);
        run_txn(0, 1, 32'h0000_3002, 32'h1234_BEEF,  2'b01, 0, 0, 2,  32'h0);
        run_txn(0, 1, 32'h0000_3000, 32'hDEAD_BEEF,  2'b11, 0, 0, 0,  32'h0);
        run_txn(1, 1, 32'h0000_6000, 32'h5555_5555,  2'b10, 0, 1, 0,  32'h0BAD_CAFE);
        run_txn(1, 0, 32'h0000_7001, 32'h0,          2'b00, 0, 0, 3,  32'h0000_9C00);

        // reset while a fetch sits in ACCESS
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'hBFC0_0010; cpu_size = 2'b10;
        cpu_signed = 1'b0; ir_write = 1'b1; waitrequest = 1'b1; readdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_read", 32'(read), 32'h1);
        reset = 1'b1;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        exp_instr = RST_INSTR;
        chk("midrst_read", 32'(read), 32'h0);
        chk("midrst_instr", instr, RST_INSTR);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_stall", 32'(stall), 32'h1);
        reset = 1'b0;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        run_txn(1, 0, 32'hBFC0_0010, 32'h0, 2'b10, 0, 1, 1, 32'h1357_9BDF);

        for (int i = 0; i < 250; i++) begin
            int unsigned kind;
            logic        rd, wr, sgn, irw;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          waits;
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            sz = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b10) addr[1:0] = 2'b00;
                else if (sz == 2'b01) addr[0] = 1'b0;
            end
            sgn = 1'($urandom_range(0, 1));
            irw = 1'($urandom_range(0, 1));
            waits = int'($urandom_range(0, 5));
            run_txn(rd, wr, addr, $urandom, sz, sgn, irw, waits, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
